audio_lj_master: RTL and testbench

- Master-mode left-justified audio serial port: generates AUD_BCLK and the two LR clocks from clk, serializes parallel ADC-side stereo samples onto AUD_ADCDAT, and deserializes AUD_DACDAT into parallel stereo samples.
- It is the clock-owning end of the codec serial link. It drives a codec strapped in slave mode, and is the synthesizable codec model the audio_codec interface is verified against.

---
 rtl/audio_lj_master.sv | 159 +++++++++++++++
 tb/tb_audio_lj_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_lj_master.sv
// Master-mode left-justified audio port: owns BCLK/LRCK, serializes ADC pairs, deserializes DAC pairs.
// Latency: an accepted pair is sent from the next frame start; received pairs appear one clk after the right-slot LSB.
// Backpressure: single holding register, adc_ready low while it is full; an empty holding register at frame start sends zeros and sets adc_underrun.
module audio_lj_master #(
    parameter int AUDIO_DATA_WIDTH = 24,
    parameter int BCLK_DIV         = 8,
    parameter int BITS_PER_CHANNEL = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AUDIO_DATA_WIDTH-1:0] adc_left,
    input  logic [AUDIO_DATA_WIDTH-1:0] adc_right,
    input  logic                        adc_valid,
    output logic                        adc_ready,
    output logic                        adc_underrun,
    output logic [AUDIO_DATA_WIDTH-1:0] dac_left,
    output logic [AUDIO_DATA_WIDTH-1:0] dac_right,
    output logic                        dac_valid,
    output logic                        AUD_BCLK,
    output logic                        AUD_ADCLRCK,
    output logic                        AUD_DACLRCK,
    output logic                        AUD_ADCDAT,
    input  logic                        AUD_DACDAT
);
    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = (BITS_PER_CHANNEL > 1) ? $clog2(BITS_PER_CHANNEL) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_CHANNEL - 1);
    localparam logic [BW-1:0] W_LAST   = BW'(W - 1);
    localparam logic [BW:0]   W_LIM    = (BW + 1)'(W);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          bclk;
    logic          lrck;
    logic          adcdat;

    logic          hold_full;
    logic [W-1:0]  hold_left;
    logic [W-1:0]  hold_right;
    logic [W-1:0]  stage_right;
    logic [W-1:0]  tx_sr;

    logic [W-1:0]  rx_left;
    logic [W-1:0]  rx_right;
    logic          have_left;
    logic          dac_load;

    logic tc, rise_ev, fall_ev, bit_wrap, frame_start, right_start, in_data, last_data_bit;

    always_comb begin
        tc            = (div_cnt == DIV_LAST);
        rise_ev       = tc && !bclk;
        fall_ev       = tc && bclk;
        bit_wrap      = (bit_cnt == BIT_LAST);
        frame_start   = fall_ev && bit_wrap && !lrck;
        right_start   = fall_ev && bit_wrap && lrck;
        in_data       = ({1'b0, bit_cnt} < W_LIM);
        last_data_bit = (bit_cnt == W_LAST);
    end

    assign adc_ready   = !hold_full;
    assign AUD_BCLK    = bclk;
    assign AUD_ADCLRCK = lrck;
    assign AUD_DACLRCK = lrck;
    assign AUD_ADCDAT  = adcdat;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            bit_cnt      <= BIT_LAST;
            bclk         <= 1'b0;
            lrck         <= 1'b0;
            adcdat       <= 1'b0;
            hold_full    <= 1'b0;
            hold_left    <= '0;
            hold_right   <= '0;
            stage_right  <= '0;
            tx_sr        <= '0;
            rx_left      <= '0;
            rx_right     <= '0;
            have_left    <= 1'b0;
            dac_load     <= 1'b0;
            dac_left     <= '0;
            dac_right    <= '0;
            dac_valid    <= 1'b0;
            adc_underrun <= 1'b0;
        end else begin
            dac_valid <= 1'b0;
            dac_load  <= 1'b0;
            if (dac_load) begin
                dac_left  <= rx_left;
                dac_right <= rx_right;
                dac_valid <= 1'b1;
            end

            if (tc) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // Bit k of a slot is launched on the fall that moves the counter to k.
            if (fall_ev) begin
                bit_cnt <= bit_wrap ? '0 : bit_cnt + 1'b1;
                if (bit_wrap) begin
                    lrck <= ~lrck;
                end
                if (frame_start) begin
                    if (hold_full) begin
                        adcdat      <= hold_left[W-1];
                        tx_sr       <= hold_left << 1;
                        stage_right <= hold_right;
                    end else begin
                        adcdat       <= 1'b0;
                        tx_sr        <= '0;
                        stage_right  <= '0;
                        adc_underrun <= 1'b1;
                    end
                end else if (right_start) begin
                    adcdat <= stage_right[W-1];
                    tx_sr  <= stage_right << 1;
                end else begin
                    adcdat <= tx_sr[W-1];
                    tx_sr  <= tx_sr << 1;
                end
            end

            // Frame start consumes the holding register before any same-cycle offer can refill it.
            if (frame_start && hold_full) begin
                hold_full <= 1'b0;
            end else if (adc_valid && !hold_full) begin
                hold_left  <= adc_left;
                hold_right <= adc_right;
                hold_full  <= 1'b1;
            end

            if (rise_ev && in_data) begin
                if (lrck) begin
                    rx_left <= {rx_left[W-2:0], AUD_DACDAT};
                end else begin
                    rx_right <= {rx_right[W-2:0], AUD_DACDAT};
                end
            end

            // A right slot only completes a pair once a left slot has been received since reset.
            if (rise_ev && last_data_bit) begin
                if (lrck) begin
                    have_left <= 1'b1;
                end else if (have_left) begin
                    dac_load <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_lj_master.sv
// Bench for audio_lj_master: event-count reference model checked every cycle, plus literal frame checks.
module tb_audio_lj_master;
    localparam int W   = 24;
    localparam int D   = 2;
    localparam int BPC = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] adc_left = '0, adc_right = '0;
    logic         adc_valid = 1'b0;
    logic         adc_ready, adc_underrun, dac_valid;
    logic [W-1:0] dac_left, dac_right;
    logic         AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT, AUD_DACDAT;
    logic         loop = 1'b0;
    logic         din_rand = 1'b0;
    logic         mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    assign AUD_DACDAT = loop ? AUD_ADCDAT : din_rand;

    audio_lj_master #(.AUDIO_DATA_WIDTH(W), .BCLK_DIV(D), .BITS_PER_CHANNEL(BPC)) dut (
        .clk(clk), .reset(reset),
        .adc_left(adc_left), .adc_right(adc_right), .adc_valid(adc_valid),
        .adc_ready(adc_ready), .adc_underrun(adc_underrun),
        .dac_left(dac_left), .dac_right(dac_right), .dac_valid(dac_valid),
        .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_DACLRCK(AUD_DACLRCK),
        .AUD_ADCDAT(AUD_ADCDAT), .AUD_DACDAT(AUD_DACDAT)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs derived from the number of clk edges since reset.
    int           n;
    logic         m_bclk, m_lrck, m_adcdat, m_full, m_underrun, m_dv, pend;
    logic [W-1:0] m_hl, m_hr, m_cur, m_stage, m_rl, m_rr, m_dl, m_dr;

    always @(posedge clk) begin
        if (reset) begin
            n = 0; m_bclk = 0; m_lrck = 0; m_adcdat = 0; m_full = 0; m_underrun = 0;
            m_dv = 0; pend = 0; m_hl = '0; m_hr = '0; m_cur = '0; m_stage = '0;
            m_rl = '0; m_rr = '0; m_dl = '0; m_dr = '0;
        end else begin : step
            int m, f, k, s;
            logic din_bit, full_before;
            din_bit     = loop ? m_adcdat : din_rand;
            full_before = m_full;
            m_dv = pend;
            if (pend) begin
                m_dl = m_rl;
                m_dr = m_rr;
            end
            pend = 0;
            n++;
            if (n % D == 0) begin
                m = n / D;
                m_bclk = (m % 2 == 1);
                if (m % 2 == 0) begin
                    f = m / 2; k = (f - 1) % BPC; s = (f - 1) / BPC;
                    m_lrck = (s % 2 == 0);
                    if (k == 0) begin
                        if (s % 2 == 0) begin
                            if (full_before) begin
                                m_cur = m_hl; m_stage = m_hr; m_full = 0;
                            end else begin
                                m_cur = '0; m_stage = '0; m_underrun = 1;
                            end
                        end else begin
                            m_cur = m_stage;
                        end
                    end
                    m_adcdat = (k < W) ? m_cur[W-1-k] : 1'b0;
                end else begin
                    f = (m - 1) / 2;
                    if (f >= 1) begin
                        k = (f - 1) % BPC; s = (f - 1) / BPC;
                        if (k < W) begin
                            if (s % 2 == 0) m_rl[W-1-k] = din_bit;
                            else            m_rr[W-1-k] = din_bit;
                        end
                        if (k == W - 1 && s % 2 == 1) pend = 1;
                    end
                end
            end
            if (adc_valid && !full_before) begin
                m_full = 1; m_hl = adc_left; m_hr = adc_right;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("bclk", 64'(AUD_BCLK), 64'(m_bclk));
            check("adclrck", 64'(AUD_ADCLRCK), 64'(m_lrck));
            check("daclrck", 64'(AUD_DACLRCK), 64'(m_lrck));
            check("adcdat", 64'(AUD_ADCDAT), 64'(m_adcdat));
            check("adc_ready", 64'(adc_ready), 64'(!m_full));
            check("underrun", 64'(adc_underrun), 64'(m_underrun));
            check("dac_valid", 64'(dac_valid), 64'(m_dv));
            check("dac_left", 64'(dac_left), 64'(m_dl));
            check("dac_right", 64'(dac_right), 64'(m_dr));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1; adc_valid = 0; loop = 0;
        repeat (3) @(negedge clk);
        reset = 0;
    endtask

    task automatic wait_bclk_rise();
        logic p;
        bit ok;
        ok = 0;
        p = AUD_BCLK;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!p && AUD_BCLK) begin ok = 1; break; end
            p = AUD_BCLK;
        end
        if (!ok) check("bclk_rise_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_lrck_rise();
        logic p;
        bit ok;
        ok = 0;
        p = AUD_ADCLRCK;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (!p && AUD_ADCLRCK) begin ok = 1; break; end
            p = AUD_ADCLRCK;
        end
        if (!ok) check("lrck_rise_timeout", 64'd0, 64'd1);
    endtask

    task automatic collect_frame(output logic [63:0] v);
        v = '0;
        wait_lrck_rise();
        for (int i = 0; i < 64; i++) begin
            wait_bclk_rise();
            v = {v[62:0], AUD_ADCDAT};
        end
    endtask

    initial begin
        logic [63:0] fr;
        logic        acc;
        int          cnt, last, t;

        // Reset state
        repeat (2) @(negedge clk);
        mon_en = 1;
        check("rst_bclk", 64'(AUD_BCLK), 64'd0);
        check("rst_lrck", 64'({AUD_ADCLRCK, AUD_DACLRCK}), 64'd0);
        check("rst_ready", 64'(adc_ready), 64'd1);
        check("rst_dac", 64'({dac_valid, dac_left, dac_right}), 64'd0);

        // Pair offered before the first frame
        reset = 0;
        adc_left = 24'hA5C3F1; adc_right = 24'h0F0F0F; adc_valid = 1;
        @(negedge clk);
        adc_valid = 0;
        collect_frame(fr);
        check("frame_a5c3f1", fr, {24'hA5C3F1, 8'h00, 24'h0F0F0F, 8'h00});

        // Underrun: no offer for a frame
        do_reset();
        wait_lrck_rise();
        check("ready_at_start", 64'(adc_ready), 64'd1);
        acc = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            acc |= AUD_ADCDAT;
        end
        check("underrun_zeros", 64'(acc), 64'd0);
        check("underrun_set", 64'(adc_underrun), 64'd1);
        repeat (300) @(negedge clk);
        check("underrun_sticky", 64'(adc_underrun), 64'd1);

        // Offer lands on the same edge as the first frame start
        do_reset();
        repeat (3) @(negedge clk);
        adc_left = 24'h123456; adc_right = 24'hFEDCBA; adc_valid = 1;
        @(negedge clk);
        adc_valid = 0;
        check("same_cycle_underrun", 64'(adc_underrun), 64'd1);
        check("same_cycle_ready", 64'(adc_ready), 64'd0);
        collect_frame(fr);
        check("same_cycle_next_frame", fr, {24'h123456, 8'h00, 24'hFEDCBA, 8'h00});

        // Loopback with a constant pair
        do_reset();
        loop = 1; adc_left = 24'h800001; adc_right = 24'h7FFFFE; adc_valid = 1;
        cnt = 0; last = 0;
        for (t = 1; t <= 1300; t++) begin
            @(negedge clk);
            if (dac_valid) begin
                check("loop_left", 64'(dac_left), 64'(24'h800001));
                check("loop_right", 64'(dac_right), 64'(24'h7FFFFE));
                if (cnt > 0) check("loop_spacing", 64'(t - last), 64'd256);
                cnt++;
                last = t;
            end
        end
        check("loop_pulses", 64'(cnt), 64'd5);

        // Reset in the middle of a right slot, then restart
        for (int i = 0; i < 700 && AUD_ADCLRCK; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        check("mid_right_slot", 64'(AUD_ADCLRCK), 64'd0);
        reset = 1;
        @(negedge clk);
        check("mid_rst_outs", 64'({AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT, adc_underrun, dac_valid}), 64'd0);
        check("mid_rst_ready", 64'(adc_ready), 64'd1);
        check("mid_rst_dac", 64'({dac_left, dac_right}), 64'd0);
        @(negedge clk);
        reset = 0;
        t = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (AUD_ADCLRCK) begin t = i; break; end
        end
        check("restart_lrck_edge", 64'(t), 64'd4);
        check("restart_on_fall", 64'(AUD_BCLK), 64'd0);
        repeat (600) @(negedge clk);

        // Random offers and random serial input
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            adc_valid = ($urandom_range(0, 199) == 0);
            adc_left  = W'($urandom);
            adc_right = W'($urandom);
            din_rand  = 1'($urandom);
            @(negedge clk);
        end
        adc_valid = 0;

        // Random offers in loopback
        do_reset();
        loop = 1;
        for (int i = 0; i < 3000; i++) begin
            adc_valid = ($urandom_range(0, 99) < 2);
            adc_left  = W'($urandom);
            adc_right = W'($urandom);
            @(negedge clk);
        end
        adc_valid = 0;
        @(negedge clk);
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
